// File: rtl/sha1_sequencer_if.sv
// Handshake and sequencing bundle between the OTP/HMAC controller and the SHA-1 sequencer.
// Controller side (master) drives start/last/abort; sequencer side (slave) drives round/step and status.
// Ports: start, last, abort (ctrl->seq); round[6:0], step[4:0], w_req, first_blk, dout_valid, busy, done (seq->ctrl/datapath).
interface sha1_sequencer_if;
    logic       start;
    logic       last;
    logic       abort;
    logic [6:0] round;
    logic [4:0] step;
    logic       w_req;
    logic       first_blk;
    logic       dout_valid;
    logic       busy;
    logic       done;

    modport master (
        output start, last, abort,
        input  round, step, w_req, first_blk, dout_valid, busy, done
    );

    modport slave (
        input  start, last, abort,
        output round, step, w_req, first_blk, dout_valid, busy, done
    );
endinterface

// File: rtl/sha1_sequencer.sv
// Round/step sequencer for the bit-serial SHA-1 block datapath (load, 80 rounds, digest shift-out).
// Latency: start sampled at edge E, round 0 / step 0 visible after E; one bit per clk, no stalls.
// Backpressure: none; start is only honoured in IDLE/WAIT, abort cancels from any state.
// Ports: clk, rst_n (async active-low); seq (slave modport): start/last/abort in,
//        round/step/w_req/first_blk/dout_valid/busy/done out (all registered).
module sha1_sequencer #(
    parameter int LOAD_ROUNDS = 16,
    parameter int LAST_ROUND  = 95,
    parameter int OUT_WORDS   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    sha1_sequencer_if.slave seq
);

    localparam logic [6:0] C_LOAD      = 7'(LOAD_ROUNDS);
    localparam logic [6:0] C_LAST      = 7'(LAST_ROUND);
    localparam logic [6:0] C_OUT_FIRST = 7'(LAST_ROUND + 1);
    localparam logic [6:0] C_OUT_LAST  = 7'(LAST_ROUND + OUT_WORDS);
    localparam logic [4:0] C_STEP_LAST = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t     r_state;
    logic [6:0] r_round;
    logic [4:0] r_step;
    logic       r_last;
    logic       r_w_req;
    logic       r_first_blk;
    logic       r_dout_valid;
    logic       r_busy;
    logic       r_done;

    logic       w_step_end;
    logic [6:0] w_round_nxt;

    assign w_step_end  = (r_step == C_STEP_LAST);
    assign w_round_nxt = r_round + 7'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_round      <= 7'd0;
            r_step       <= 5'd0;
            r_last       <= 1'b0;
            r_w_req      <= 1'b0;
            r_first_blk  <= 1'b1;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (seq.abort) begin
            // Abort beats start in the same cycle and never produces a done pulse.
            r_state      <= S_IDLE;
            r_round      <= 7'd0;
            r_step       <= 5'd0;
            r_last       <= 1'b0;
            r_w_req      <= 1'b0;
            r_first_blk  <= 1'b1;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_WAIT: begin
                    if (seq.start) begin
                        r_state     <= S_RUN;
                        r_round     <= 7'd0;
                        r_step      <= 5'd0;
                        r_last      <= seq.last;
                        r_busy      <= 1'b1;
                        // Round 0 is always a message-load round.
                        r_w_req     <= 1'b1;
                        // From IDLE the datapath starts from the IV, from WAIT it chains.
                        r_first_blk <= (r_state == S_IDLE);
                    end
                end

                S_RUN: begin
                    if (!w_step_end) begin
                        r_step <= r_step + 5'd1;
                    end else if (r_round != C_LAST) begin
                        r_step  <= 5'd0;
                        r_round <= w_round_nxt;
                        r_w_req <= (w_round_nxt < C_LOAD);
                    end else if (r_last) begin
                        r_state      <= S_OUT;
                        r_round      <= C_OUT_FIRST;
                        r_step       <= 5'd0;
                        r_w_req      <= 1'b0;
                        r_dout_valid <= 1'b1;
                    end else begin
                        // Block finished but more follow: park with the chaining value selected.
                        r_state     <= S_WAIT;
                        r_round     <= 7'd0;
                        r_step      <= 5'd0;
                        r_w_req     <= 1'b0;
                        r_busy      <= 1'b0;
                        r_first_blk <= 1'b0;
                    end
                end

                S_OUT: begin
                    if (!w_step_end) begin
                        r_step <= r_step + 5'd1;
                    end else if (r_round != C_OUT_LAST) begin
                        r_step  <= 5'd0;
                        r_round <= w_round_nxt;
                    end else begin
                        r_state      <= S_FIN;
                        r_round      <= 7'd0;
                        r_step       <= 5'd0;
                        r_dout_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_first_blk  <= 1'b1;
                    end
                end

                S_FIN: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_round      <= 7'd0;
                    r_step       <= 5'd0;
                    r_w_req      <= 1'b0;
                    r_first_blk  <= 1'b1;
                    r_dout_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

    assign seq.round      = r_round;
    assign seq.step       = r_step;
    assign seq.w_req      = r_w_req;
    assign seq.first_blk  = r_first_blk;
    assign seq.dout_valid = r_dout_valid;
    assign seq.busy       = r_busy;
    assign seq.done       = r_done;

endmodule
